rca_seq_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 8-bit ripple-carry adder (rca_8_bit), one byte per clock, LSB byte first.
Carry is held in a register between bytes.
Start/ready/done handshake.
Sits between the ALU issue logic and the shared byte adder, so wide arithmetic does not need a wide adder.

---
 rtl/rca_ctrl_pkg.sv | 12 +
 rtl/rca_8_bit.sv | 20 ++
 rtl/rca_seq_add_ctrl.sv | 126 ++++++++++++
 tb/tb_rca_seq_add_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_ctrl_pkg.sv
// Shared constants for the byte-serial add/subtract sequencer.
package rca_ctrl_pkg;
  localparam int BYTE_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic bit width_ok(int w);
    return (w >= BYTE_W) && ((w % BYTE_W) == 0);
  endfunction
endpackage

// File: rtl/rca_8_bit.sv
// Plain 8-bit ripple-carry adder shared by the sequencer.
module rca_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [7:0] sum
);
  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// File: rtl/rca_seq_add_ctrl.sv
// WIDTH-bit add/subtract done one byte per clock through a single rca_8_bit,
// LSB byte first, with the inter-byte carry held in a register.
module rca_seq_add_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("rca_seq_add_ctrl: WIDTH must be a multiple of 8 and at least 8");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BYTE_W-1:0] a_byte, b_byte, rca_sum;
  logic              rca_cout;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte = a_q[i*BYTE_W +: BYTE_W];
        b_byte = b_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  rca_8_bit u_rca (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_q),
    .cout (rca_cout),
    .sum  (rca_sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*BYTE_W +: BYTE_W] = rca_sum;
        end
        carry_d = rca_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NBYTES - 1)) begin
          cout_d  = rca_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Directed bench for rca_seq_add_ctrl: a 32-bit instance and an 8-bit instance.
module tb_rca_seq_add_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start, sub;
  logic [31:0] a, b;
  logic        ready, busy, done, cout, overflow;
  logic [31:0] sum;

  logic       start8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  int checks;
  int failures;

  rca_seq_add_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  rca_seq_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(1'b0), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen; 20 means it never came.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags ready=%b busy=%b done=%b want 1 0 0", ready, busy, done);
    end
    checks++;
    if (sum !== 32'h0 || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_result sum=%h cout=%b ovf=%b want 0 0 0", sum, cout, overflow);
    end
  endtask

  task automatic test_add();
    int lat;
    issue(32'h3F3F3F3F, 32'h55555555, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL add_latency got=%0d want=4", lat);
    end
    checks++;
    if (sum !== 32'h94949494 || cout !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL add_result sum=%h cout=%b ovf=%b want 94949494 0 1", sum, cout, overflow);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || sum !== 32'h94949494) begin
      failures++;
      $display("FAIL add_after_done ready=%b done=%b sum=%h want 1 0 94949494", ready, done, sum);
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 4 || sum !== 32'h0 || cout !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ripple_all lat=%0d sum=%h cout=%b ovf=%b want 4 00000000 1 0", lat, sum, cout, overflow);
    end
    issue(32'h000000FF, 32'h00000001, 1'b0);
    wait_done(lat);
    checks++;
    if (sum !== 32'h00000100 || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ripple_byte0 sum=%h cout=%b ovf=%b want 00000100 0 0", sum, cout, overflow);
    end
  endtask

  task automatic test_subtract();
    int lat;
    issue(32'd5, 32'd7, 1'b1);
    wait_done(lat);
    checks++;
    if (sum !== 32'hFFFFFFFE || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow sum=%h cout=%b ovf=%b want FFFFFFFE 0 0", sum, cout, overflow);
    end
    issue(32'h80000000, 32'd1, 1'b1);
    wait_done(lat);
    checks++;
    if (sum !== 32'h7FFFFFFF || cout !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL sub_overflow sum=%h cout=%b ovf=%b want 7FFFFFFF 1 1", sum, cout, overflow);
    end
  endtask

  task automatic test_handshake();
    int ndone;
    issue(32'h11111111, 32'h22222222, 1'b0);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hs_run_flags ready=%b busy=%b want 0 1", ready, busy);
    end
    // Second start during RUN with different operands must be dropped.
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (sum !== 32'h00000033) begin
      failures++;
      $display("FAIL hs_partial_sum sum=%h want 00000033", sum);
    end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        checks++;
        if (sum !== 32'h33333333 || cout !== 1'b0 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL hs_result sum=%h cout=%b ovf=%b want 33333333 0 0", sum, cout, overflow);
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL hs_done_count got=%0d want=1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(32'h00000010, 32'h00000020, 1'b0);
    wait_done(lat);
    // Start raised in DONE is ignored; it is accepted at the next edge in IDLE.
    a = 32'h01020304; b = 32'h10203040; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || sum !== 32'h00000030) begin
      failures++;
      $display("FAIL b2b_idle ready=%b busy=%b sum=%h want 1 0 00000030", ready, busy, sum);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sum !== 32'h0) begin
      failures++;
      $display("FAIL b2b_accept busy=%b sum=%h want 1 00000000", busy, sum);
    end
    wait_done(lat);
    checks++;
    if (lat !== 4 || sum !== 32'h11223344) begin
      failures++;
      $display("FAIL b2b_result lat=%0d sum=%h want 4 11223344", lat, sum);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int ndone;
    issue(32'h12345678, 32'h11111111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid ready=%b busy=%b done=%b sum=%h want 1 0 0 00000000", ready, busy, done, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL rst_no_done got=%0d want=0", ndone);
    end
    issue(32'd1, 32'd1, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 4 || sum !== 32'd2 || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_fresh_add lat=%0d sum=%h cout=%b ovf=%b want 4 00000002 0 0", lat, sum, cout, overflow);
    end
  endtask

  task automatic test_width8();
    int lat;
    @(negedge clk);
    a8 = 8'hC8; b8 = 8'h64; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL w8_latency got=%0d want=1", lat);
    end
    checks++;
    if (sum8 !== 8'h2C || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_result sum=%h cout=%b ovf=%b want 2C 1 0", sum8, cout8, ovf8);
    end
    @(negedge clk);
    checks++;
    if (ready8 !== 1'b1 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_after ready=%b done=%b busy=%b want 1 0 0", ready8, done8, busy8);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_carry_ripple();
    test_subtract();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
